// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: tracks instructions from EX to WB, selects EX
// operand bypass sources, stalls on load-use, and kills young stages on taken branches.
module pipe_hazard_ctrl #(
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 1,
  parameter int CNTW     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [AW-1:0]              id_rs_i,
  input  logic [AW-1:0]              id_rt_i,
  input  logic                       id_uses_rt_i,
  input  logic [AW-1:0]              id_dst_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_memread_i,
  input  logic                       br_taken_i,
  output logic                       stall_o,
  output logic                       flush_o,
  output logic [$clog2(DEPTH)-1:0]   fwd_rs_o,
  output logic [$clog2(DEPTH)-1:0]   fwd_rt_o,
  output logic [CNTW-1:0]            stall_cnt_o,
  output logic [CNTW-1:0]            flush_cnt_o
);

  localparam int SW = $clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    logic          regwrite;
    logic          memread;
  } entry_t;

  entry_t trk_q [DEPTH];
  entry_t id_entry;
  logic   load_hit;

  assign id_entry = '{valid: id_valid_i, rs: id_rs_i, rt: id_rt_i, dst: id_dst_i,
                      regwrite: id_regwrite_i, memread: id_memread_i};

  // A load whose data is not yet forwardable sits in a stage below LOAD_LAT.
  always_comb begin
    load_hit = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (trk_q[j].valid && trk_q[j].memread && (trk_q[j].dst != '0) &&
          ((trk_q[j].dst == id_rs_i) || (id_uses_rt_i && (trk_q[j].dst == id_rt_i))))
        load_hit = 1'b1;
    end
  end

  assign flush_o = br_taken_i;
  assign stall_o = id_valid_i && !flush_o && load_hit;

  // Scan oldest to youngest so the youngest matching producer overwrites last.
  always_comb begin
    fwd_rs_o = '0;
    fwd_rt_o = '0;
    if (trk_q[0].valid) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (trk_q[k].valid && trk_q[k].regwrite && (trk_q[k].dst != '0)) begin
          if (trk_q[k].dst == trk_q[0].rs) fwd_rs_o = SW'(k);
          if (trk_q[k].dst == trk_q[0].rt) fwd_rt_o = SW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < DEPTH; k++) trk_q[k] <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      trk_q[0] <= (flush_o || stall_o) ? '0 : id_entry;
      // Stages younger than the branch are killed; the branch stage and older advance.
      for (int k = 1; k < DEPTH; k++)
        trk_q[k] <= (flush_o && (k <= BR_STAGE)) ? '0 : trk_q[k-1];
      if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNTW'(1);
      if (flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNTW'(1);
    end
  end

endmodule
